// File: rtl/ddr_rd_pkg.sv
// rtl/ddr_rd_pkg.sv - shared types and AXI constants for the DDR read-bandwidth sequencer
// Contents:
//   state_e        : sequencer states
//   AXI_BURST_INCR : arburst encoding for incrementing bursts
//   AXI_RESP_OKAY  : rresp encoding for a good beat
//   burst_bytes()  : bytes covered by one burst
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [31:0] burst_bytes(input int burst_len, input int data_w);
        return 32'(burst_len * (data_w / 8));
    endfunction

endpackage

// File: rtl/ddr_rd_lane_sum.sv
// rtl/ddr_rd_lane_sum.sv - reduces all 32-bit lanes of a read beat to one wrapping 32-bit sum
// Ports:
//   data_i : one read-data beat, DATA_W bits (multiple of 32)
//   sum_o  : sum of the DATA_W/32 lanes, modulo 2^32
module ddr_rd_lane_sum #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [31:0]       sum_o
);

    localparam int LANES = DATA_W / 32;

    always_comb begin
        sum_o = 32'd0;
        for (int i = 0; i < LANES; i++) begin
            sum_o = sum_o + data_i[i*32 +: 32];
        end
    end

endmodule

// File: rtl/ddr_rd_burst_ctrl.sv
// rtl/ddr_rd_burst_ctrl.sv - DDR read-bandwidth sequencer issuing fixed-length AXI4 INCR read bursts
// Optional feature macro: DDR_RD_PROBE_EN (registered five-word debug probe; probe is 0 without it)
// Ports:
//   m_axi_aclk, m_axi_areset      : clock, asynchronous active-high reset
//   start, base_addr, cfg_nbursts : run control; a rising edge of start launches a run
//   m_axi_ar*                     : read address channel (master side)
//   m_axi_r*                      : read data channel (master side)
//   partial_sum, cycle_cnt        : wrapping data sum and busy-cycle count of the current run
//   busy, done, err               : run status; err is sticky until the next launch
//   probe                         : {cycle_cnt, beats, completed, issued, status} when enabled
module ddr_rd_burst_ctrl
    import ddr_rd_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int MAX_OUT   = 4
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_areset,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       cfg_nbursts,
    output logic [31:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [31:0]       partial_sum,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cycle_cnt,
    output logic [159:0]      probe
);

    localparam logic [31:0]       BURST_BYTES = burst_bytes(BURST_LEN, DATA_W);
    localparam logic [31:0]       ADDR_MASK   = ~(BURST_BYTES - 32'd1);
    localparam int                BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(1);
    localparam logic [3:0]        MAX_OUT_C   = 4'(MAX_OUT);

    state_e            state_q, state_d;
    logic              start_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       addr_q;
    logic [15:0]       nb_q;
    logic [15:0]       issued_q;
    logic [3:0]        out_q, out_d;
    logic [BEAT_W-1:0] beat_q;
    logic [31:0]       sum_q;
    logic [31:0]       cyc_q;
    logic [31:0]       lane_sum;

    logic start_edge, launch, busy_w;
    logic ar_hs, r_hs, rlast_dec;

    assign start_edge = start && !start_q;
    assign launch     = (state_q == ST_IDLE) && start_edge;
    assign busy_w     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign ar_hs      = m_axi_arvalid && m_axi_arready;
    assign r_hs       = m_axi_rvalid && m_axi_rready;
    // A stray rlast with nothing outstanding must not wrap the counter.
    assign rlast_dec  = r_hs && m_axi_rlast && (out_q != 4'd0);

    ddr_rd_lane_sum #(.DATA_W(DATA_W)) u_lane_sum (
        .data_i (m_axi_rdata),
        .sum_o  (lane_sum)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = (cfg_nbursts == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ar_hs && (16'(issued_q + 16'd1) == nb_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // out_q==0 only after malformed rlast traffic; finish rather than hang.
                if ((rlast_dec && (out_q == 4'd1)) || (out_q == 4'd0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (ar_hs && !rlast_dec) begin
            out_d = out_q + 4'd1;
        end else if (!ar_hs && rlast_dec) begin
            out_d = out_q - 4'd1;
        end
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b1;   // a start level held through reset is not an edge
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 32'd0;
            nb_q     <= 16'd0;
            issued_q <= 16'd0;
            out_q    <= 4'd0;
            beat_q   <= '0;
            sum_q    <= 32'd0;
            cyc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            // done is held back one cycle so the results are settled when it rises.
            done_q  <= (state_q == ST_DONE) && (state_d == ST_DONE);
            if (launch) begin
                addr_q   <= base_addr & ADDR_MASK;
                nb_q     <= cfg_nbursts;
                err_q    <= 1'b0;
                issued_q <= 16'd0;
                out_q    <= 4'd0;
                beat_q   <= '0;
                sum_q    <= 32'd0;
                cyc_q    <= 32'd0;
            end else begin
                out_q <= out_d;
                if (ar_hs) begin
                    addr_q   <= addr_q + BURST_BYTES;
                    issued_q <= issued_q + 16'd1;
                end
                if (r_hs) begin
                    sum_q  <= sum_q + lane_sum;
                    beat_q <= (m_axi_rlast || (beat_q == LAST_BEAT)) ? '0 : beat_q + BEAT_ONE;
                    if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != (beat_q == LAST_BEAT))) begin
                        err_q <= 1'b1;
                    end
                end
                if (busy_w) begin
                    cyc_q <= cyc_q + 32'd1;
                end
            end
        end
    end

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
    assign m_axi_arburst = AXI_BURST_INCR;
    // Depends only on registers, so it stays up with a stable address until accepted.
    assign m_axi_arvalid = (state_q == ST_RUN) && (issued_q < nb_q) && (out_q < MAX_OUT_C);
    assign m_axi_rready  = busy_w;
    assign busy          = busy_w;
    assign done          = done_q;
    assign err           = err_q;
    assign partial_sum   = sum_q;
    assign cycle_cnt     = cyc_q;

`ifdef DDR_RD_PROBE_EN
    logic [31:0]  comp_q;
    logic [31:0]  beats_q;
    logic [159:0] probe_q;

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            comp_q  <= 32'd0;
            beats_q <= 32'd0;
            probe_q <= '0;
        end else begin
            if (launch) begin
                comp_q  <= 32'd0;
                beats_q <= 32'd0;
            end else begin
                if (rlast_dec) begin
                    comp_q <= comp_q + 32'd1;
                end
                if (r_hs) begin
                    beats_q <= beats_q + 32'd1;
                end
            end
            probe_q <= {cyc_q, beats_q, comp_q, 32'(issued_q),
                        27'd0, state_q, err_q, busy_w, done_q};
        end
    end

    assign probe = probe_q;
`else
    assign probe = '0;
`endif

endmodule

// File: doc/ddr_rd_burst_ctrl.md
# ddr_rd_burst_ctrl

Sequencer for the DDR read-bandwidth test. On a rising edge of `start`, it issues a configured number of fixed-length AXI4 INCR read bursts from a base address, keeping a bounded number of bursts in flight. It accumulates a 32-bit sum of all returned data and counts elapsed cycles. It sits between the AXI-lite register file (START, DDR base address, partial-sum and probe registers) and the HP/DDR AXI master port.

## Interface
Parameters:
- `DATA_W`, 64: read data width in bits; a multiple of 32, at most 128.
- `BURST_LEN`, 16: beats per burst; `arlen` = `BURST_LEN`-1.
- `MAX_OUT`, 4: maximum outstanding bursts, 1..15.

Ports:
- `m_axi_aclk`, in, 1: sole clock.
- `m_axi_areset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: level from the register file; only a rising edge matters.
- `base_addr`, in, 32: test start address.
- `cfg_nbursts`, in, 16: number of bursts to issue.
- `m_axi_araddr`, out, 32
- `m_axi_arlen`, out, 8
- `m_axi_arsize`, out, 3
- `m_axi_arburst`, out, 2
- `m_axi_arvalid`, out, 1
- `m_axi_arready`, in, 1
- `m_axi_rdata`, in, `DATA_W`
- `m_axi_rresp`, in, 2
- `m_axi_rlast`, in, 1
- `m_axi_rvalid`, in, 1
- `m_axi_rready`, out, 1
- `partial_sum`, out, 32: wrapping sum of all 32-bit lanes of all beats.
- `busy`, out, 1
- `done`, out, 1
- `err`, out, 1: sticky error flag.
- `cycle_cnt`, out, 32
- `probe`, out, 160: debug words feeding the register-file probe input.

## Operation
- States:
  - IDLE: waiting for a start edge.
  - RUN: issuing bursts.
  - DRAIN: all bursts issued, waiting for data.
  - DONE: test finished.
- IDLE→RUN: `start` is 1 this cycle and was 0 the previous cycle. On that edge, latch `base_addr` with its low log2(`BURST_LEN`·`DATA_W`/8) bits forced to 0, and latch `cfg_nbursts`. Clear `partial_sum`, `cycle_cnt`, `err` and all counters. If `cfg_nbursts`=0, go to DONE instead.
- Address of burst k = latched base + k·`BURST_LEN`·`DATA_W`/8, modulo 2^32 (it wraps).
- `arlen`, `arsize` (log2(`DATA_W`/8)) and `arburst` (INCR) are constants.
- In RUN, `arvalid`=1 while issued<nbursts and outstanding<`MAX_OUT`. Once asserted, `arvalid` and `araddr` hold stable until `arready`.
- Outstanding counter:
  - +1 on an AR handshake.
  - −1 on an R handshake with `rlast`.
  - Unchanged when both happen in the same cycle.
- RUN→DRAIN: on the AR handshake of the last burst.
- DRAIN→DONE: the cycle after the final `rlast` handshake.
- `rready`=1 in RUN and DRAIN, 0 otherwise.
- Each R handshake adds the sum of all `DATA_W`/32 lanes of `rdata` to `partial_sum`, modulo 2^32.
- `err` is set by either condition, and stays set until the next accepted start:
  - `rresp`≠OKAY on any beat;
  - `rlast` on any beat other than beat `BURST_LEN`-1, or missing on that beat.
- Errors do not abort the run.
- `cycle_cnt` increments every cycle in RUN and DRAIN and freezes in DONE.
- DONE→IDLE: when `start`=0. A `start` that stays high never retriggers.
- `start` dropping during RUN or DRAIN is ignored; the run completes.
- `busy`=1 in RUN and DRAIN.
- `done`=1 in DONE.

## Timing
- Reset values: all outputs 0, except the constant fields `arlen`, `arsize` and `arburst`; state IDLE.
- Reset takes effect asynchronously, including mid-burst. After reset, the edge detector's previous-`start` value is 1, so a `start` held high through reset does not launch a run.
- Latency from the start edge to the first `arvalid`: 1 cycle.
- Latency from an R handshake to the updated `partial_sum`: 1 cycle.
- `done` rises with `partial_sum` and `cycle_cnt` already final.
- Back-to-back AR issue: one burst per cycle while `arready`=1 and the outstanding limit permits.

## Configuration
`DDR_RD_PROBE_EN`:
- Defined: the 160-bit `probe` output carries five 32-bit words, all registered:
  - word0: {state[1:0], err, busy, done}, zero-extended;
  - word1: issued count;
  - word2: completed-burst count;
  - word3: total beat count;
  - word4: `cycle_cnt`.
- Undefined: `probe` is tied to 0 and the probe counters are not built.

## Structure
- Package `ddr_rd_pkg`: state enum, AXI burst type and response constants (INCR=2'b01, OKAY=2'b00), and a function computing burst bytes.
- Sub-module `ddr_rd_lane_sum`: combinational adder reducing `DATA_W`/32 lanes to 32 bits, modulo 2^32.

## Test plan
- `cfg_nbursts`=0, start edge → `done`=1 two cycles after the edge; no `arvalid`; `partial_sum`=0.
- Base 0x1000_0000, nbursts=4, each beat `rdata`={32'h0, 32'h1} → `araddr` 0x1000_0000, 0x1000_0080, 0x1000_0100, 0x1000_0180; `partial_sum`=64; `err`=0.
- nbursts=8, `MAX_OUT`=4, R channel stalled 20 cycles → exactly 4 ARs accepted, then `arvalid`=0 until the first `rlast`; `araddr` stable whenever `arvalid` is held.
- One beat returns `rresp`=SLVERR → `err`=1, run completes with `done`=1; the next start edge clears `err` to 0.
- Base 0xFFFF_FF84, nbursts=2 → `araddr` 0xFFFF_FF80, then 0x0000_0000.
- `m_axi_areset` pulsed during DRAIN with `start` held high → outputs 0 immediately; no new run until `start` goes 0 and then 1.
